// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: read-port bundle between the FIFO, the arbiter
// and its consumers. slave = arbiter side, master = FIFO/consumer side.
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]    req;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [NUM_REQ-1:0]    rd_valid;
  logic                  busy;

  modport slave (
    input  req,
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en,
    output grant,
    output rd_data,
    output rd_valid,
    output busy
  );

  modport master (
    output req,
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en,
    input  grant,
    input  rd_data,
    input  rd_valid,
    input  busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst scheduler for the FIFO read port.
// Ports: clk, rst (async, active-high), bus (req/empty/data in; rd_en/grant/rd_data/rd_valid/busy out).
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_rd_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         last_q, last_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [IW-1:0]         win;
  logic                  found;
  logic                  rd_en;

  logic                  pend_q;
  logic [IW-1:0]         pidx_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_REQ-1:0]    rd_valid_q;

  // Scan upward from the requester after the last owner, so the
  // previous owner is considered only after everyone else.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req[(int'(last_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|bus.req) && !bus.fifo_empty) begin
          state_d = BURST;
          owner_d = win;
          grant_d = NUM_REQ'(1) << win;
          beat_d  = '0;
        end
      end
      BURST: begin
        rd_en = bus.req[owner_q] & ~bus.fifo_empty;
        if (rd_en) begin
          beat_d = beat_q + 1'b1;
        end
        if ((rd_en && (beat_q == LAST_BEAT)) ||
            !bus.req[owner_q] || bus.fifo_empty) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Return path runs on its own so the last beat still lands after
  // the FSM has already released the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pidx_q     <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      pend_q <= rd_en;
      pidx_q <= owner_q;
      if (pend_q) begin
        rd_valid_q <= NUM_REQ'(1) << pidx_q;
        rd_data_q  <= bus.fifo_rd_data;
      end else begin
        rd_valid_q <= '0;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.grant      = grant_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.busy       = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed bench with a small FIFO model and
// event logs of reads, returns and grants.
module tb_fifo_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) ifc ();

  fifo_rd_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  logic [7:0] mem [256];
  int   wp = 0;
  int   rp = 0;
  int   cyc = 0;
  int   viol = 0;
  logic flush = 1'b0;
  logic clr = 1'b0;
  logic [3:0] gprev = '0;

  int         en_cyc[$];
  logic [3:0] en_gnt[$];
  int         v_cyc[$];
  logic [7:0] v_dat[$];
  logic [3:0] v_own[$];
  logic [3:0] g_log[$];

  int nchk = 0;
  int nfail = 0;
  int n0;

  assign ifc.fifo_empty = (wp == rp);

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    gprev <= ifc.grant;
    if (flush) begin
      rp <= wp;
    end else if (ifc.fifo_rd_en) begin
      ifc.fifo_rd_data <= mem[rp[7:0]];
      rp <= rp + 1;
    end
    if (ifc.fifo_rd_en && ifc.fifo_empty) viol <= viol + 1;
    if (clr) begin
      en_cyc.delete();
      en_gnt.delete();
      v_cyc.delete();
      v_dat.delete();
      v_own.delete();
      g_log.delete();
    end else begin
      if (ifc.fifo_rd_en) begin
        en_cyc.push_back(cyc);
        en_gnt.push_back(ifc.grant);
      end
      if (ifc.rd_valid != 4'b0) begin
        v_cyc.push_back(cyc);
        v_dat.push_back(ifc.rd_data);
        v_own.push_back(ifc.rd_valid);
      end
      if (ifc.grant != 4'b0 && ifc.grant != gprev)
        g_log.push_back(ifc.grant);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp[7:0]] = d;
    wp = wp + 1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    ifc.req = '0;
    rst   = 1'b1;
    flush = 1'b1;
    clr   = 1'b1;
    cyc_n(2);
    flush = 1'b0;
    clr   = 1'b0;
    rst   = 1'b0;
    cyc_n(1);
  endtask

  initial begin
    ifc.req = '0;
    #2;
    rst   = 1'b1;
    flush = 1'b1;
    clr   = 1'b1;
    #1;
    check("rst_grant", ifc.grant, 4'b0);
    check("rst_rd_valid", ifc.rd_valid, 4'b0);
    check("rst_rd_data", ifc.rd_data, 8'h00);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_rd_en", ifc.fifo_rd_en, 1'b0);
    cyc_n(2);
    flush = 1'b0;
    clr   = 1'b0;
    rst   = 1'b0;
    cyc_n(1);

    // single requester, 10 words -> bursts 4,4,2
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
    ifc.req = 4'b0001;
    cyc_n(20);
    check("t1_reads", en_cyc.size(), 10);
    check("t1_returns", v_cyc.size(), 10);
    check("t1_bursts", g_log.size(), 3);
    if (en_cyc.size() == 10 && v_cyc.size() == 10) begin
      for (int i = 0; i < 9; i++)
        check("t1_gap", en_cyc[i+1] - en_cyc[i], (i % 4 == 3) ? 2 : 1);
      for (int i = 0; i < 10; i++) begin
        check("t1_lat", v_cyc[i] - en_cyc[i], 2);
        check("t1_data", v_dat[i], 8'(8'h10 + i));
        check("t1_own", v_own[i], 4'b0001);
      end
    end
    check("t1_busy_end", ifc.busy, 1'b0);
    check("t1_grant_end", ifc.grant, 4'b0);

    // all four requesting, FIFO never empty
    do_reset();
    for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
    ifc.req = 4'b1111;
    for (int k = 0; k < 200 && en_cyc.size() < 16; k++) @(negedge clk);
    ifc.req = 4'b0000;
    cyc_n(4);
    check("t2_reads", en_cyc.size(), 16);
    check("t2_returns", v_cyc.size(), 16);
    check("t2_grants", g_log.size(), 4);
    if (en_cyc.size() == 16 && v_cyc.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("t2_rr", en_gnt[i], 4'b0001 << ((i / 4) % 4));
        check("t2_own", v_own[i], en_gnt[i]);
        check("t2_data", v_dat[i], 8'(8'h40 + i));
      end
    end

    // empty stall, then refill
    do_reset();
    push(8'hA0);
    push(8'hA1);
    ifc.req = 4'b0100;
    cyc_n(8);
    check("t3_reads", en_cyc.size(), 2);
    check("t3_grants", g_log.size(), 1);
    if (en_cyc.size() == 2)
      check("t3_gap", en_cyc[1] - en_cyc[0], 1);
    if (g_log.size() == 1)
      check("t3_g0", g_log[0], 4'b0100);
    check("t3_busy_empty", ifc.busy, 1'b0);
    check("t3_grant_empty", ifc.grant, 4'b0);
    push(8'hA2);
    cyc_n(6);
    check("t3_reads2", en_cyc.size(), 3);
    check("t3_grants2", g_log.size(), 2);
    if (g_log.size() == 2)
      check("t3_g1", g_log[1], 4'b0100);
    if (v_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t3_data", v_dat[i], 8'(8'hA0 + i));
        check("t3_own", v_own[i], 4'b0100);
      end
    end else begin
      check("t3_returns", v_cyc.size(), 3);
    end

    // requester withdraws after 2 beats
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
    ifc.req = 4'b0010;
    for (int k = 0; k < 50 && en_cyc.size() < 2; k++) @(negedge clk);
    ifc.req = 4'b0000;
    #1;
    check("t4_no_third", ifc.fifo_rd_en, 1'b0);
    check("t4_grant_held", ifc.grant, 4'b0010);
    @(posedge clk);
    #1;
    check("t4_grant_clr", ifc.grant, 4'b0);
    check("t4_busy_clr", ifc.busy, 1'b0);
    cyc_n(4);
    check("t4_reads", en_cyc.size(), 2);
    check("t4_returns", v_cyc.size(), 2);
    if (v_cyc.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        check("t4_data", v_dat[i], 8'(8'hC0 + i));
        check("t4_own", v_own[i], 4'b0010);
      end
    end

    // async reset with returns in flight
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'hE0 + i));
    ifc.req = 4'b0001;
    for (int k = 0; k < 50 && v_cyc.size() < 1; k++) @(negedge clk);
    check("t5_pre_valid", ifc.rd_valid, 4'b0001);
    check("t5_pre_busy", ifc.busy, 1'b1);
    n0 = v_cyc.size();
    #1;
    rst = 1'b1;
    #1;
    check("t5_grant", ifc.grant, 4'b0);
    check("t5_rd_valid", ifc.rd_valid, 4'b0);
    check("t5_busy", ifc.busy, 1'b0);
    check("t5_rd_en", ifc.fifo_rd_en, 1'b0);
    cyc_n(3);
    check("t5_discard", v_cyc.size(), n0);
    clr = 1'b1;
    cyc_n(1);
    clr = 1'b0;
    ifc.req = 4'b1111;
    rst = 1'b0;
    for (int k = 0; k < 50 && g_log.size() < 1; k++) @(negedge clk);
    check("t5_grants", g_log.size() >= 1, 1'b1);
    if (g_log.size() >= 1)
      check("t5_first", g_log[0], 4'b0001);
    ifc.req = 4'b0000;
    cyc_n(2);

    check("never_rd_empty", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
